// File: rtl/filter_seq_ctrl.sv
// Sampling sequencer between the pad ring and the FILTER core: paces samples, runs the ADC
// convert/read handshake, hands samples to the filter and writes results to the DAC.
module filter_seq_ctrl #(
  parameter int SAMPLE_DIV   = 100,
  parameter int CONV_TIMEOUT = 64,
  parameter int RD_CYCLES    = 2,
  parameter int WR_CYCLES    = 2
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       ADC_Eoc,
  input  logic [7:0] ADC_Data,
  output logic       ADC_Convst,
  output logic       ADC_cs,
  output logic       ADC_Rd,
  output logic [7:0] Sample_Out,
  output logic       Sample_Valid,
  input  logic [7:0] Result_In,
  input  logic       Result_Valid,
  output logic [7:0] DAC_Data,
  output logic       DAC_cs,
  output logic       DAC_WR,
  output logic       LDAC,
  output logic       CLR,
  input  logic       Flag_Clr,
  output logic       Overrun,
  output logic       Timeout
);

  localparam int PER_W    = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int TMO_W    = $clog2(CONV_TIMEOUT + 1);
  localparam int STRB_MAX = (RD_CYCLES > WR_CYCLES) ? ((RD_CYCLES > 2) ? RD_CYCLES : 2)
                                                    : ((WR_CYCLES > 2) ? WR_CYCLES : 2);
  localparam int STRB_W   = $clog2(STRB_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CONVST, S_WAIT_EOC, S_READ, S_PROC, S_WRITE, S_LOAD
  } state_e;

  state_e            state_q;
  logic [PER_W-1:0]  period_q, period_d;
  logic [TMO_W-1:0]  tmo_q;
  logic [STRB_W-1:0] strb_q;
  logic              eoc_meta_q, eoc_s_q;
  logic [1:0]        clr_cnt_q;
  logic              clr_n_q;
  logic              convst_n_q, adc_cs_n_q, adc_rd_n_q;
  logic              dac_cs_n_q, dac_wr_n_q, ldac_n_q;
  logic [7:0]        sample_q, dac_data_q;
  logic              sample_valid_q;
  logic              overrun_q, overrun_d, timeout_q, timeout_d;
  logic              tick, tmo_event;

  assign tick      = (period_q == PER_W'(SAMPLE_DIV - 1));
  assign tmo_event = (state_q == S_WAIT_EOC) && eoc_s_q && (tmo_q == TMO_W'(CONV_TIMEOUT - 1));

  // NOTE: every signal assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    period_d  = tick ? '0 : period_q + 1'b1;
    overrun_d = overrun_q & ~Flag_Clr;
    timeout_d = timeout_q & ~Flag_Clr;
    if (tick && (state_q != S_IDLE)) overrun_d = 1'b1;
    if (tmo_event)                   timeout_d = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      period_q  <= '0;
      overrun_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      period_q  <= period_d;
      overrun_q <= overrun_d;
      timeout_q <= timeout_d;
    end
  end

  // NOTE: synchronizer resets to the inactive (high) level so reset cannot fake an EOC.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      eoc_meta_q <= 1'b1;
      eoc_s_q    <= 1'b1;
    end else begin
      eoc_meta_q <= ADC_Eoc;
      eoc_s_q    <= eoc_meta_q;
    end
  end

  // DAC clear is held for four cycles after reset release, then stays released.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      clr_cnt_q <= '0;
      clr_n_q   <= 1'b0;
    end else if (!clr_n_q) begin
      if (clr_cnt_q == 2'd3) clr_n_q   <= 1'b1;
      else                   clr_cnt_q <= clr_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q        <= S_IDLE;
      tmo_q          <= '0;
      strb_q         <= '0;
      convst_n_q     <= 1'b1;
      adc_cs_n_q     <= 1'b1;
      adc_rd_n_q     <= 1'b1;
      dac_cs_n_q     <= 1'b1;
      dac_wr_n_q     <= 1'b1;
      ldac_n_q       <= 1'b1;
      sample_q       <= '0;
      sample_valid_q <= 1'b0;
      dac_data_q     <= '0;
    end else begin
      sample_valid_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (tick) begin
            state_q    <= S_CONVST;
            convst_n_q <= 1'b0;
            strb_q     <= '0;
          end
        end
        S_CONVST: begin
          if (strb_q == STRB_W'(1)) begin
            state_q    <= S_WAIT_EOC;
            convst_n_q <= 1'b1;
            tmo_q      <= '0;
          end else begin
            strb_q <= strb_q + 1'b1;
          end
        end
        S_WAIT_EOC: begin
          if (!eoc_s_q) begin
            state_q    <= S_READ;
            adc_cs_n_q <= 1'b0;
            adc_rd_n_q <= 1'b0;
            strb_q     <= '0;
          end else if (tmo_event) begin
            state_q <= S_IDLE;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        S_READ: begin
          if (strb_q == STRB_W'(RD_CYCLES - 1)) begin
            state_q        <= S_PROC;
            adc_cs_n_q     <= 1'b1;
            adc_rd_n_q     <= 1'b1;
            sample_q       <= ADC_Data;
            sample_valid_q <= 1'b1;
          end else begin
            strb_q <= strb_q + 1'b1;
          end
        end
        S_PROC: begin
          if (Result_Valid) begin
            state_q    <= S_WRITE;
            dac_data_q <= Result_In;
            dac_cs_n_q <= 1'b0;
            dac_wr_n_q <= 1'b0;
            strb_q     <= '0;
          end
        end
        S_WRITE: begin
          if (strb_q == STRB_W'(WR_CYCLES - 1)) begin
            state_q    <= S_LOAD;
            dac_cs_n_q <= 1'b1;
            dac_wr_n_q <= 1'b1;
            ldac_n_q   <= 1'b0;
          end else begin
            strb_q <= strb_q + 1'b1;
          end
        end
        S_LOAD: begin
          state_q  <= S_IDLE;
          ldac_n_q <= 1'b1;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign ADC_Convst   = convst_n_q;
  assign ADC_cs       = adc_cs_n_q;
  assign ADC_Rd       = adc_rd_n_q;
  assign Sample_Out   = sample_q;
  assign Sample_Valid = sample_valid_q;
  assign DAC_Data     = dac_data_q;
  assign DAC_cs       = dac_cs_n_q;
  assign DAC_WR       = dac_wr_n_q;
  assign LDAC         = ldac_n_q;
  assign CLR          = clr_n_q;
  assign Overrun      = overrun_q;
  assign Timeout      = timeout_q;

endmodule

// File: doc/filter_seq_ctrl.md
# filter_seq_ctrl

Sampling sequencer sitting between the pad ring and the FILTER core: paces the sample rate, drives the ADC convert/read handshake, presents each captured sample to the filter, and writes the filter result to the DAC with a write strobe followed by a load pulse. All external converter strobes are active-low and registered; the filter side is a single-cycle valid pulse in each direction.

## Interface
- SAMPLE_DIV, 100, clock cycles per sample period (≥ 16)
- CONV_TIMEOUT, 64, max cycles to wait for end-of-conversion
- RD_CYCLES, 2, ADC cs/rd low width in cycles (≥ 1)
- WR_CYCLES, 2, DAC cs/wr low width in cycles (≥ 1)
- CLK  in  1  system clock; one clock domain
- RESET  in  1  asynchronous, active-high reset
- ADC_Eoc  in  1  end of conversion, active-low, asynchronous to CLK
- ADC_Data  in  8  ADC parallel data
- ADC_Convst  out  1  convert start, active-low
- ADC_cs  out  1  ADC chip select, active-low
- ADC_Rd  out  1  ADC read strobe, active-low
- Sample_Out  out  8  captured sample to filter
- Sample_Valid  out  1  one-cycle pulse, Sample_Out valid
- Result_In  in  8  filter result
- Result_Valid  in  1  one-cycle pulse, Result_In valid
- DAC_Data  out  8  DAC parallel data
- DAC_cs, DAC_WR  out  1 each  DAC select/write, active-low
- LDAC  out  1  DAC load, active-low
- CLR  out  1  DAC clear, active-low
- Flag_Clr  in  1  clears sticky flags
- Overrun  out  1  sticky: sample tick while busy
- Timeout  out  1  sticky: EOC not seen within CONV_TIMEOUT

## Operation
- Period counter 0..SAMPLE_DIV-1, free-running, wraps; tick asserted when count == SAMPLE_DIV-1.
- ADC_Eoc passes a 2-flop synchronizer; eoc_s = synchronized value.
- FSM: IDLE, CONVST, WAIT_EOC, READ, PROC, WRITE, LOAD.
- IDLE: tick -> CONVST.
- CONVST: ADC_Convst low for exactly 2 cycles -> WAIT_EOC; timeout counter cleared.
- WAIT_EOC: eoc_s==0 -> READ; counter reaching CONV_TIMEOUT -> set Timeout, -> IDLE (no sample, no DAC write).
- READ: ADC_cs and ADC_Rd low for RD_CYCLES cycles; ADC_Data captured into Sample_Out on last READ cycle; -> PROC with Sample_Valid high for first PROC cycle.
- PROC: wait Result_Valid; on pulse DAC_Data <= Result_In, -> WRITE. No timeout; only RESET leaves PROC without a result.
- WRITE: DAC_cs and DAC_WR low for WR_CYCLES cycles; DAC_Data stable throughout and held until next update -> LOAD.
- LOAD: LDAC low 1 cycle -> IDLE.
- Tick in any state other than IDLE: set Overrun, tick dropped, current sequence unaffected.
- Result_Valid outside PROC: ignored.
- Flag_Clr clears Overrun/Timeout; a set event in the same cycle wins.
- CLR: low while RESET and for 4 cycles after RESET deasserts, then high permanently.

## Timing
- All outputs registered; reset values: ADC_Convst, ADC_cs, ADC_Rd, DAC_cs, DAC_WR, LDAC = 1; CLR = 0; Sample_Out, DAC_Data = 0; Sample_Valid, Overrun, Timeout = 0; FSM IDLE; period counter 0.
- Tick in cycle T: ADC_Convst low in T+1, T+2.
- ADC_Eoc falling before edge E: READ begins at E+3 (2 sync + state update).
- Sample_Valid in cycle after last READ cycle.
- Result_Valid in cycle R: DAC_cs/DAC_WR low R+1..R+WR_CYCLES; LDAC low R+WR_CYCLES+1; IDLE at R+WR_CYCLES+2.
- RESET mid-sequence: all strobes return high immediately (asynchronous), FSM IDLE, counter restarts; no partial DAC load.

## Test plan
- Reset: hold RESET 5 cycles -> all strobes 1, CLR 0; after release CLR stays 0 exactly 4 cycles then 1; first ADC_Convst low at cycle 100 after release (SAMPLE_DIV=100).
- Nominal loop: EOC model asserts 10 cycles after Convst, ADC_Data=0xA5, filter echoes Result_In=0x5A 3 cycles after Sample_Valid -> Sample_Out=0xA5 with one pulse, ADC_Rd low 2 cycles, DAC_WR low 2 cycles, DAC_Data=0x5A, one LDAC pulse, IDLE before next tick.
- Timeout: ADC_Eoc held high -> Timeout sets after 64 cycles in WAIT_EOC, no ADC_Rd/DAC_WR/LDAC activity, next tick starts new conversion.
- Overrun: SAMPLE_DIV=16, filter holds Result_Valid off 40 cycles -> Overrun sets, only one DAC write occurs for that sequence; Flag_Clr pulse clears it.
- Reset mid-WRITE: assert RESET while DAC_WR low -> DAC_WR and DAC_cs high same cycle (async), LDAC never pulses, CLR low.
- Flag_Clr coincident with timeout event -> Timeout remains 1.
